// File: rtl/count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor_if
// Description : Bundles the observed count bus, the statistics clear and the
//               monitor status/statistics outputs.
//               master : drives y and clr, observes status (counter/testbench)
//               slave  : samples y and clr, drives status (count_monitor)
// Signals     : y          [W-1:0] count value under observation
//               clr                synchronous clear of err_cnt / wrap_cnt
//               locked             monitor is in the LOCKED state
//               err_pulse          one-cycle step-error pulse
//               wrap_pulse         one-cycle wrap-around pulse
//               err_cnt    [7:0]   saturating error count
//               wrap_cnt   [7:0]   wrap count, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
interface count_monitor_if #(
    parameter int W = 8
);
    logic [W-1:0] y;
    logic         clr;
    logic         locked;
    logic         err_pulse;
    logic         wrap_pulse;
    logic [7:0]   err_cnt;
    logic [7:0]   wrap_cnt;

    modport master (
        output y,
        output clr,
        input  locked,
        input  err_pulse,
        input  wrap_pulse,
        input  err_cnt,
        input  wrap_cnt
    );

    modport slave (
        input  y,
        input  clr,
        output locked,
        output err_pulse,
        output wrap_pulse,
        output err_cnt,
        output wrap_cnt
    );
endinterface : count_monitor_if
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Receive-side checker for a free-running counter bus. Locks
//               onto a clean +1 sequence, then flags every broken step and
//               counts wrap-arounds. All outputs are registered.
// Ports       : clk   - sole clock, rising edge
//               res   - asynchronous active-low reset
//               bus   - count_monitor_if.slave (y, clr in; status out)
// Parameters  : W           - count bus width
//               LOCK_CYCLES - consecutive good steps needed to lock (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module count_monitor #(
    parameter int W           = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  wire                   clk,
    input  wire                   res,
    count_monitor_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]   c_lock_run = 4'(LOCK_CYCLES);
    localparam logic [W-1:0] c_all_ones = {W{1'b1}};

    state_t       state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic [3:0]   run_q, run_d;
    logic         err_pulse_q, err_pulse_d;
    logic         wrap_pulse_q, wrap_pulse_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic [7:0]   wrap_cnt_q, wrap_cnt_d;

    logic         w_good;
    logic [3:0]   w_run_inc;

    // The +1 comparison wraps naturally at W bits, so all-ones -> 0 is good.
    assign w_good    = (bus.y == prev_q + W'(1));
    assign w_run_inc = run_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        prev_d       = bus.y;
        run_d        = run_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // First edge after reset only seeds prev.
                state_d = ST_SYNC;
                run_d   = 4'd0;
            end
            ST_SYNC: begin
                // Errors are never reported while hunting for lock.
                if (w_good) begin
                    if (w_run_inc == c_lock_run) begin
                        state_d = ST_LOCKED;
                        run_d   = 4'd0;
                    end else begin
                        run_d = w_run_inc;
                    end
                end else begin
                    run_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (w_good) begin
                    if (prev_q == c_all_ones) begin
                        wrap_pulse_d = 1'b1;
                        wrap_cnt_d   = wrap_cnt_q + 8'd1;
                    end
                end else begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ST_SYNC;
                    run_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = 4'd0;
            end
        endcase

        // Clear wins over any increment on the same edge; pulses untouched.
        if (bus.clr) begin
            err_cnt_d  = 8'd0;
            wrap_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            run_q        <= 4'd0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_cnt_q    <= 8'd0;
            wrap_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.wrap_cnt   = wrap_cnt_q;

endmodule : count_monitor
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_monitor
// Description : Self-checking bench for count_monitor: vector table for lock,
//               skip, stall, SYNC silence and wrap; hand sequences for async
//               reset mid-lock, error-count saturation and clear priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

    typedef struct {
        logic       res;
        logic [7:0] y;
        logic       clr;
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] err_cnt;
        logic [7:0] wrap_cnt;
    } vec_t;

    logic clk;
    logic res;
    int   checks;
    int   errors;
    vec_t vecs[$];

    count_monitor_if #(.W(8)) bus ();

    count_monitor #(
        .W           (8),
        .LOCK_CYCLES (4)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic e,
                           input logic w, input int ec, input int wc);
        chk({tag, " locked"},     int'(bus.locked),     int'(l));
        chk({tag, " err_pulse"},  int'(bus.err_pulse),  int'(e));
        chk({tag, " wrap_pulse"}, int'(bus.wrap_pulse), int'(w));
        chk({tag, " err_cnt"},    int'(bus.err_cnt),    ec);
        chk({tag, " wrap_cnt"},   int'(bus.wrap_cnt),   wc);
    endtask

    // Drive y/clr, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [7:0] yv, input logic c);
        bus.y   = yv;
        bus.clr = c;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] yv, input logic c,
                                input logic l, input logic e, input logic w,
                                input logic [7:0] ec, input logic [7:0] wc);
        vec_t v;
        v.res = r; v.y = yv; v.clr = c; v.locked = l; v.err = e; v.wrap = w;
        v.err_cnt = ec; v.wrap_cnt = wc;
        return v;
    endfunction

    initial begin
        logic [7:0] cur;
        checks  = 0;
        errors  = 0;
        res     = 1'b0;
        bus.y   = 8'd0;
        bus.clr = 1'b0;

        // ---------------- vector table ----------------
        // reset held
        vecs.push_back(mk(0, 8'd7, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'd9, 1, 0, 0, 0, 0, 0));
        // clean stream from release: lock after the fifth edge (y=4)
        vecs.push_back(mk(1, 8'd0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'd1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'd2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'd3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'd4, 0, 1, 0, 0, 0, 0));
        for (int i = 5; i <= 11; i++)
            vecs.push_back(mk(1, 8'(i), 0, 1, 0, 0, 0, 0));
        // skip 11 -> 13
        vecs.push_back(mk(1, 8'd13, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 8'd14, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 8'd15, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 8'd16, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 8'd17, 0, 1, 0, 0, 1, 0));
        // stall while locked, then garbage in SYNC is silent
        for (int i = 18; i <= 21; i++)
            vecs.push_back(mk(1, 8'(i), 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 8'd21, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk(1, 8'd21, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 8'd5,  0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 8'd6,  0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 8'd7,  0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 8'd8,  0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 8'd9,  0, 1, 0, 0, 2, 0));
        // jump to 250 (error), relock, then wrap while locked
        vecs.push_back(mk(1, 8'd250, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 8'd251, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 8'd252, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 8'd253, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 8'd254, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mk(1, 8'd255, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mk(1, 8'd0,   0, 1, 0, 1, 3, 1));
        vecs.push_back(mk(1, 8'd1,   0, 1, 0, 0, 3, 1));

        #2;
        chk_all("reset_initial", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            res = vecs[i].res;
            step(vecs[i].y, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err,
                    vecs[i].wrap, int'(vecs[i].err_cnt), int'(vecs[i].wrap_cnt));
        end

        // ---------------- async reset while locked, err_cnt=3 ----------------
        #3;
        res = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        step(8'd2, 0);
        step(8'd3, 0);
        chk_all("reset_hold", 0, 0, 0, 0, 0);
        res = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            step(8'(i), 0);
            chk($sformatf("relock_pre%0d locked", i), int'(bus.locked), 0);
        end
        step(8'd4, 0);
        chk_all("relock_edge5", 1, 0, 0, 0, 0);

        // ---------------- saturation: 300 errors, each followed by relock ----
        cur = 8'd4;
        for (int n = 1; n <= 300; n++) begin
            cur = cur + 8'd2;
            step(cur, 0);
            chk($sformatf("sat%0d err_pulse", n), int'(bus.err_pulse), 1);
            chk($sformatf("sat%0d err_cnt", n), int'(bus.err_cnt), (n > 255) ? 255 : n);
            for (int k = 0; k < 4; k++) begin
                cur = cur + 8'd1;
                step(cur, 0);
            end
            chk($sformatf("sat%0d relock", n), int'(bus.locked), 1);
        end

        // wrap to make wrap_cnt nonzero, then clear coinciding with an error
        step(8'd250, 0);
        chk("sat_hold err_cnt", int'(bus.err_cnt), 255);
        for (int i = 251; i <= 255; i++) step(8'(i), 0);
        step(8'd0, 0);
        chk("pre_clr wrap_pulse", int'(bus.wrap_pulse), 1);
        chk("pre_clr wrap_cnt", int'(bus.wrap_cnt), 1);
        step(8'd5, 1);
        chk_all("clr_with_err", 0, 1, 0, 0, 0);
        step(8'd6, 0);
        chk_all("after_clr", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_count_monitor
`default_nettype wire

// File: doc/count_monitor.md
# count_monitor

Receive-side checker for the free-running 8-bit counter output bus. Samples the count value every clock and locks onto a clean +1 sequence. Once locked, it reports every broken step (skip, stall, backward jump) and every wrap-around. It sits beside the counter in the episode designs as a self-checking consumer, and its statistics can be read from a testbench or debug logic.

## Interface
- W, default 8: width of the count bus and of the internal previous-value register.
- LOCK_CYCLES, default 4: number of consecutive good +1 steps required to enter lock (legal range 1..15).
- clk  input  1  sole clock; every register updates on its rising edge.
- res  input  1  asynchronous, active-low reset. Asserting it clears all state immediately, with no clock needed.
- y  input  W  count value under observation; sampled on every rising clk.
- clr  input  1  synchronous clear of err_cnt and wrap_cnt. Active high, one cycle is enough.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse for each step error detected while LOCKED.
- wrap_pulse  output  1  one-cycle pulse for each all-ones -> 0 step detected while LOCKED.
- err_cnt  output  8  saturating error count; sticks at 255.
- wrap_cnt  output  8  wrap count, modulo 256.

## Operation
- Internal registers: prev (W bits), run (4 bits), state (IDLE, SYNC, LOCKED).
- A good step means y == prev + 1 mod 2^W. A step from all-ones to 0 is good.
- prev <= y on every clock in every state.
- IDLE (entered on reset):
  - Next edge captures prev only.
  - Then -> SYNC with run = 0.
- SYNC:
  - Good step: run <= run + 1.
  - Any other step: run <= 0. No error is reported in SYNC.
  - When the increment would make run == LOCK_CYCLES: state <= LOCKED, run <= 0.
- LOCKED:
  - Good step: stay LOCKED. If prev was all-ones, also pulse wrap_pulse and increment wrap_cnt.
  - Bad step (including stall y == prev): pulse err_pulse, increment err_cnt (saturating at 255), state <= SYNC, run <= 0.
- clr:
  - Forces err_cnt and wrap_cnt to 0 on that edge.
  - Beats a simultaneous increment: the result is 0, not 1.
  - Does not affect state, prev, run, or the pulses.
- Reset values: locked=0, err_pulse=0, wrap_pulse=0, err_cnt=0, wrap_cnt=0; internally state=IDLE, prev=0, run=0.
- Reset asserted mid-operation, including while LOCKED:
  - All outputs go to reset values immediately.
  - Operation resumes in IDLE on the first edge after res returns high.
- All outputs are registered; none depends combinationally on y or clr.

## Timing
- Latency: each pulse and counter update is visible right after the rising edge that samples the offending or wrapping y value, one clock after y presents it.
- Lock time with a clean stream from reset release:
  - Edge 1 captures prev.
  - Edges 2..LOCK_CYCLES+1 are good steps.
  - locked rises after edge LOCK_CYCLES+1, which is edge 5 at the default.
- Relock after an error:
  - The erroring sample becomes the new prev.
  - locked rises after LOCK_CYCLES further good steps.
- locked falls on the same edge that raises err_pulse.
- Pulses are exactly one cycle wide. Back-to-back events cannot occur, because an error drops lock and wraps are at least 2^W cycles apart.
- wrap_pulse and err_pulse are never high together.

## Test plan
- Reset and lock:
  - Stimulus: hold res=0, then feed y = 0,1,2,... from reset release.
  - Required: all outputs 0 during reset; locked rises after the 5th sampled edge (y=4); no pulses.
- Skip error:
  - Stimulus: while locked, feed 10,11,13,14,15,16,17.
  - Required: err_pulse high for one cycle after sampling 13; err_cnt=1; locked=0; locked returns high after sampling 17.
- Stall and SYNC silence:
  - Stimulus: while locked, feed 20,21,21; then while in SYNC, feed 21,5.
  - Required: exactly one err_pulse (for the stall); further garbage in SYNC produces no pulse; err_cnt=1.
- Wrap:
  - Stimulus: while locked, feed 254,255,0,1.
  - Required: wrap_pulse for one cycle after sampling 0; wrap_cnt=1; locked stays 1; err_cnt unchanged.
- Saturation and clear:
  - Stimulus: inject 300 errors, each followed by a relock. Then assert clr on the same edge as another error.
  - Required: err_cnt holds at 255 after the 255th error; after the clr edge err_cnt=0, with err_pulse still high for that cycle.
- Reset mid-lock:
  - Stimulus: drop res asynchronously between edges while locked with err_cnt=3.
  - Required: locked, err_cnt, and wrap_cnt go to 0 before the next edge; relock takes 5 edges after release.
